// File: rtl/pipeline_hazard_control_pkg.sv
// Shared decode classes, opcode constants and FSM encoding for the hazard control block.
// Latency: pure declarations and combinational helper functions.
// Backpressure: none; this package holds no state.
package pipeline_hazard_control_pkg;

  // RV32I major opcodes that the hazard logic cares about
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // EX, MEM and WB each hold one in-flight destination register
  localparam int SB_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
  } sb_entry_t;

  // Opcode classes that produce a register-file write
  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_R, OP_IALU, OP_LOAD, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
      default:                                                   writes_rd = 1'b0;
    endcase
  endfunction

  // Opcode classes that read rs1
  function automatic logic reads_rs1(input logic [6:0] op);
    case (op)
      OP_R, OP_IALU, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH: reads_rs1 = 1'b1;
      default:                                              reads_rs1 = 1'b0;
    endcase
  endfunction

  // Opcode classes that read rs2
  function automatic logic reads_rs2(input logic [6:0] op);
    case (op)
      OP_R, OP_STORE, OP_BRANCH: reads_rs2 = 1'b1;
      default:                   reads_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_hazard_control_scoreboard.sv
// Three-entry destination scoreboard (EX/MEM/WB) and RAW match against the decoded sources.
// Latency: hazard is combinational from the decode fields; entries shift every clock.
// Backpressure: none; a bubble inserts an invalid entry so stalled instructions never enter.
module hazard_scoreboard
  import pipeline_hazard_control_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_bubble,
  input  logic [6:0] i_opcode,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic [4:0] i_rd,
  output logic       o_hazard
);

  sb_entry_t r_sb [SB_DEPTH];
  sb_entry_t w_new;
  logic      w_chk_rs1;
  logic      w_chk_rs2;
  logic      w_hit_rs1;
  logic      w_hit_rs2;

  // Entry that would enter EX this cycle; x0 writes never create a dependency
  always_comb begin
    w_new     = '0;
    w_new.vld = ~i_bubble & writes_rd(i_opcode) & (i_rd != 5'd0);
    w_new.rd  = i_bubble ? 5'd0 : i_rd;
  end

  // Advance the in-flight destinations one stage per clock
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sb[0] <= '0;
      r_sb[1] <= '0;
      r_sb[2] <= '0;
    end else begin
      r_sb[2] <= r_sb[1];
      r_sb[1] <= r_sb[0];
      r_sb[0] <= w_new;
    end
  end

  // No forwarding and no write-through, so every valid stage including WB blocks a reader
  always_comb begin
    w_chk_rs1 = reads_rs1(i_opcode) & (i_rs1 != 5'd0);
    w_chk_rs2 = reads_rs2(i_opcode) & (i_rs2 != 5'd0);
    w_hit_rs1 = 1'b0;
    w_hit_rs2 = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (r_sb[i].vld && (r_sb[i].rd == i_rs1)) w_hit_rs1 = 1'b1;
      if (r_sb[i].vld && (r_sb[i].rd == i_rs2)) w_hit_rs2 = 1'b1;
    end
    o_hazard = (w_chk_rs1 & w_hit_rs1) | (w_chk_rs2 & w_hit_rs2);
  end

endmodule

// File: rtl/pipeline_hazard_control.sv
// Decode-stage hazard control: RAW interlock stall/bubble, redirect flush, stall-cycle counter.
// Latency: stall/bubble/flush are combinational in the cycle of their inputs; counter is registered.
// Backpressure: stall holds PC and decode; redirect always wins over a pending RAW stall.
module pipeline_hazard_control
  import pipeline_hazard_control_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [6:0]       i_id_opcode,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic [4:0]       i_id_rd,
  input  logic             i_ex_redirect,
  output logic             o_stall,
  output logic             o_bubble,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_stall_count
);

  // Cycles still owed after the redirect cycle itself
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic       FLUSH_MULTI  = (FLUSH_CYCLES > 1);

  state_e           r_state;
  logic [1:0]       r_flush_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_hazard;
  logic             w_stall;
  logic             w_bubble;
  logic             w_flush;

  hazard_scoreboard u_scoreboard (
    .i_clk    (i_clock),
    .i_reset  (i_reset),
    .i_bubble (w_bubble),
    .i_opcode (i_id_opcode),
    .i_rs1    (i_id_rs1),
    .i_rs2    (i_id_rs2),
    .i_rd     (i_id_rd),
    .o_hazard (w_hazard)
  );

  // Same-cycle control outputs; RUN and STALL share the redirect-over-hazard decision
  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    if (i_reset) begin
      w_bubble = 1'b1;
      w_flush  = 1'b1;
    end else begin
      case (r_state)
        ST_FLUSH: begin
          w_bubble = 1'b1;
          w_flush  = 1'b1;
        end
        default: begin
          if (i_ex_redirect) begin
            w_bubble = 1'b1;
            w_flush  = 1'b1;
          end else if (w_hazard) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
          end
        end
      endcase
    end
  end

  // Control FSM and flush-length counter; a redirect in any state restarts the flush window
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 2'd0;
    end else if (i_ex_redirect) begin
      r_flush_cnt <= FLUSH_RELOAD;
      r_state     <= FLUSH_MULTI ? ST_FLUSH : ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_state <= w_hazard ? ST_STALL : ST_RUN;
        end
        ST_STALL: begin
          r_state <= w_hazard ? ST_STALL : ST_RUN;
        end
        ST_FLUSH: begin
          if (r_flush_cnt <= 2'd1) begin
            r_flush_cnt <= 2'd0;
            r_state     <= ST_RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - 2'd1;
          end
        end
        default: begin
          r_flush_cnt <= 2'd0;
          r_state     <= ST_RUN;
        end
      endcase
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall       = w_stall;
  assign o_bubble      = w_bubble;
  assign o_flush       = w_flush;
  assign o_stall_count = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Randomized and directed bench against a pipeline-occupancy reference model.
// Latency: outputs sampled at the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: the bench holds the decoded instruction while stall is observed.
module tb_pipeline_hazard_control;

  localparam int FC   = 2;
  localparam int CW   = 10;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    op;
  logic [4:0]    rs1, rs2, rd;
  logic          redirect;
  logic          stall, bubble, flush;
  logic [CW-1:0] scount;

  always #5 clk = ~clk;

  pipeline_hazard_control #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .i_clock       (clk),
    .i_reset       (reset),
    .i_id_opcode   (op),
    .i_id_rs1      (rs1),
    .i_id_rs2      (rs2),
    .i_id_rd       (rd),
    .i_ex_redirect (redirect),
    .o_stall       (stall),
    .o_bubble      (bubble),
    .o_flush       (flush),
    .o_stall_count (scount)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: destinations of the last three issued instructions (0 = nothing),
  // flush cycles still owed, and the stall-cycle count.
  int hist [3];
  int flush_left;
  int mcnt;

  bit last_stall, last_bubble, last_flush;
  int last_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_writes(input logic [6:0] o);
    return o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                     7'b0110111, 7'b0010111, 7'b1101111};
  endfunction

  function automatic bit m_reads1(input logic [6:0] o);
    return o inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                     7'b0100011, 7'b1100011};
  endfunction

  function automatic bit m_reads2(input logic [6:0] o);
    return o inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction

  // One clock cycle: check outputs against the model, then advance the model
  task automatic tick();
    bit e_stall, e_bubble, e_flush, haz;
    @(negedge clk);
    e_stall = 0; e_bubble = 0; e_flush = 0; haz = 0;
    if (reset) begin
      e_bubble = 1; e_flush = 1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_reads1(op) && rs1 != 0 && hist[k] == int'(rs1)) haz = 1;
        if (m_reads2(op) && rs2 != 0 && hist[k] == int'(rs2)) haz = 1;
      end
      if (redirect || flush_left > 0) begin
        e_bubble = 1; e_flush = 1;
      end else if (haz) begin
        e_stall = 1; e_bubble = 1;
      end
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("bubble", 32'(bubble), 32'(e_bubble));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("stall_count", 32'(scount), 32'(mcnt));
    last_stall = stall; last_bubble = bubble; last_flush = flush; last_cnt = int'(scount);
    if (reset) begin
      hist = '{0, 0, 0};
      flush_left = 0;
      mcnt = 0;
    end else begin
      if (redirect) flush_left = FC - 1;
      else if (flush_left > 0) flush_left--;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = (!e_bubble && m_writes(op)) ? int'(rd) : 0;
      if (e_stall && mcnt < CMAX) mcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in decode and hold it until it issues
  task automatic issue(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, output int stalls);
    bit done;
    op = o; rs1 = a; rs2 = b; rd = d; redirect = 0;
    stalls = 0; done = 0;
    for (int g = 0; g < 8 && !done; g++) begin
      tick();
      if (last_stall) stalls++;
      else done = 1;
    end
    if (!done) chk("issue_bound", 32'(last_stall), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1; redirect = 0;
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int s;
    logic [6:0] optab [11];
    optab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0110111, 7'b0010111,
              7'b1101111, 7'b0100011, 7'b1100011, 7'b0000000, 7'b1110011};
    reset = 1; redirect = 0; op = 0; rs1 = 0; rs2 = 0; rd = 0;
    hist = '{0, 0, 0}; flush_left = 0; mcnt = 0;
    @(posedge clk);
    #1;
    do_reset();

    // add x5,x1,x2 ; add x6,x5,x3 -> three stall cycles
    issue(7'b0110011, 5'd1, 5'd2, 5'd5, s);
    chk("raw_first_no_stall", 32'(s), 32'd0);
    issue(7'b0110011, 5'd5, 5'd3, 5'd6, s);
    chk("raw_stalls", 32'(s), 32'd3);
    chk("raw_count", 32'(scount), 32'd3);

    // lw x7,0(x1) ; nop ; sw x7,4(x2) -> two stall cycles on rs2
    do_reset();
    issue(7'b0000011, 5'd1, 5'd0, 5'd7, s);
    issue(7'b0010011, 5'd0, 5'd0, 5'd0, s);
    issue(7'b0100011, 5'd2, 5'd7, 5'd4, s);
    chk("load_store_stalls", 32'(s), 32'd2);

    // addi x0,x0,1 ; add x1,x0,x0 -> x0 never interlocks
    do_reset();
    issue(7'b0010011, 5'd0, 5'd1, 5'd0, s);
    issue(7'b0110011, 5'd0, 5'd0, 5'd1, s);
    chk("x0_no_stall", 32'(s), 32'd0);

    // redirect while the decoded add has a RAW hazard
    do_reset();
    issue(7'b0110011, 5'd1, 5'd2, 5'd5, s);
    op = 7'b0110011; rs1 = 5'd5; rs2 = 5'd3; rd = 5'd6; redirect = 1;
    tick();
    chk("redir_flush", 32'(last_flush), 32'd1);
    chk("redir_bubble", 32'(last_bubble), 32'd1);
    chk("redir_stall", 32'(last_stall), 32'd0);
    redirect = 0; op = 0; rs1 = 0; rs2 = 0; rd = 0;
    tick();
    chk("redir_flush2", 32'(last_flush), 32'd1);
    chk("redir_stall2", 32'(last_stall), 32'd0);
    issue(7'b0110011, 5'd6, 5'd0, 5'd8, s);
    chk("redir_done", 32'(last_flush), 32'd0);
    chk("flushed_not_tracked", 32'(s), 32'd0);

    // reset during the second stall cycle
    do_reset();
    issue(7'b0110011, 5'd1, 5'd2, 5'd5, s);
    op = 7'b0110011; rs1 = 5'd5; rs2 = 5'd3; rd = 5'd6;
    tick();
    chk("pre_rst_stall", 32'(last_stall), 32'd1);
    reset = 1;
    tick();
    chk("rst_stall", 32'(last_stall), 32'd0);
    chk("rst_flush", 32'(last_flush), 32'd1);
    reset = 0;
    tick();
    chk("post_rst_stall", 32'(last_stall), 32'd0);
    chk("post_rst_count", 32'(last_cnt), 32'd0);

    // random instruction stream with redirects and occasional resets
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!last_stall) begin
        op  = ($urandom_range(0, 11) == 11) ? 7'($urandom) : optab[$urandom_range(0, 10)];
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
      end
      redirect = ($urandom_range(0, 9) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 0; redirect = 0;

    // back-to-back add x5,x5,x0 drives more than 2^CW+5 stall cycles
    do_reset();
    for (int n = 0; n < 360; n++) issue(7'b0110011, 5'd5, 5'd0, 5'd5, s);
    chk("sat_count", 32'(scount), 32'(CMAX));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_control.md
PIPELINE_HAZARD_CONTROL -- requirements
Module: pipeline_hazard_control

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: total cycles flush is asserted per redirect (range 1-3).
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle performance counter.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Port id_opcode, input, 7: opcode held in the decode output register.
REQ-006 Port id_rs1, input, 5: rs1 field held in the decode output register.
REQ-007 Port id_rs2, input, 5: rs2 field held in the decode output register.
REQ-008 Port id_rd, input, 5: rd field held in the decode output register.
REQ-009 Port ex_redirect, input, 1: taken branch or jump resolved in EX this cycle.
REQ-010 Port stall, output, 1: hold the PC and the decode input/output registers.
REQ-011 Port bubble, output, 1: load a NOP into the EX register instead of the decoded instruction.
REQ-012 Port flush, output, 1: drives the decode stage clear input (succ).
REQ-013 Port stall_count, output, CNT_W: number of cycles in which stall was asserted, saturating.

Function
REQ-014 Scoreboard: three entries E0 (EX), E1 (MEM), E2 (WB); each entry holds a valid bit and a 5-bit rd.
REQ-015 Writes-rd classes: R 0110011, I-alu 0010011, load 0000011, JALR 1100111, LUI 0110111, AUIPC 0010111, JAL 1101111; the entry is valid only if rd != 0.
REQ-016 Reads-rs1 classes: R, I-alu, load, JALR, S 0100011, B 1100011. Reads-rs2 classes: R, S, B. Any other opcode is treated as a NOP (no reads, no write).
REQ-017 hazard = (read rs1 != 0 and it matches any valid Ei.rd) or (read rs2 != 0 and it matches any valid Ei.rd). There is no forwarding, and E2 counts as a match because the register file is not write-through.
REQ-018 FSM states are RUN, STALL and FLUSH.
REQ-019 RUN, combinational outputs:
- ex_redirect=1: flush=1, bubble=1, stall=0; go to FLUSH with the counter set to FLUSH_CYCLES-1 (if FLUSH_CYCLES=1, stay in RUN).
- otherwise hazard=1: stall=1, bubble=1; go to STALL.
- otherwise all outputs are 0.
REQ-020 STALL:
- ex_redirect=1 takes priority exactly as in RUN.
- otherwise stall=bubble=hazard; return to RUN in the cycle after hazard clears.
REQ-021 FLUSH: flush=1, bubble=1, stall=0, and the counter decrements. Return to RUN when the counter is 0. A new ex_redirect reloads the counter.
REQ-022 Scoreboard shift every cycle: E2<=E1, E1<=E0. E0<=invalid if bubble=1, otherwise E0<={writes-rd, id_rd}.
REQ-023 Priority: redirect over hazard. Flushed instructions never enter the scoreboard.
REQ-024 stall_count increments in each cycle with stall=1 and holds at all-ones.
REQ-025 Latency: stall, bubble and flush are combinational, valid in the same cycle as their inputs. Worst-case RAW stall is 3 cycles.

Reset
REQ-026 While reset=1: stall=0, bubble=1, flush=1, and no state advances.
REQ-027 On the first edge with reset=1: E0-E2 become invalid, state becomes RUN, the flush counter becomes 0, and stall_count becomes 0.
REQ-028 Reset asserted mid-STALL or mid-FLUSH aborts the sequence. The first cycle after reset is RUN with an empty scoreboard.

Structure
REQ-029 A shared package holds the opcode constants, the FSM state encoding, and the writes-rd/reads-rs class functions.
REQ-030 One sub-module, hazard_scoreboard, owns E0-E2 and the match compare. The FSM and counters stay in the top module.

Verification
REQ-031 Sequence add x5,x1,x2 then add x6,x5,x3: the second add gives stall=1 for 3 cycles, then issues; stall_count=3.
REQ-032 Sequence lw x7,0(x1), nop, sw x7,4(x2): stall for 2 cycles on rs2=x7.
REQ-033 Sequence addi x0,x0,1 then add x1,x0,x0: no stall (x0 is excluded).
REQ-034 ex_redirect=1 while a hazard is present: flush=1, bubble=1, stall=0 for exactly 2 cycles, and the scoreboard E0 is invalid.
REQ-035 Reset pulse during the 2nd stall cycle: the next cycle is RUN with stall=0 and stall_count=0.
REQ-036 Force 2^CNT_W+5 stall cycles: stall_count saturates at all-ones.
